// File: rtl/sound_addr_sequencer.sv
// sound_addr_sequencer
// Programmable table-address generator for the sound unit. A start pulse
// latches a [start_addr, end_addr] window, a step and a mode. After that,
// each qualified slow-clock tick (tick && enable) advances the address.
// Three modes are supported: loop (wrap to the window start), one-shot
// (stop at the window end with a done pulse) and ping-pong (bounce between
// the window bounds with a wrap pulse at each turnaround).
//
// Ports:
//   clk        system clock
//   resetN     asynchronous active-low reset
//   tick       slow-clock enable, one advance per tick while enabled
//   enable     external gate; low pauses the sequencer (ticks are lost)
//   start      one-cycle pulse: latch config and run from start_addr
//   stop       one-cycle pulse: abort to idle, address holds
//   start_addr window low bound (sampled only on start)
//   end_addr   window high bound (sampled only on start)
//   step       increment per advance, 0 is treated as 1
//   mode       00 loop, 01 one-shot, 10 ping-pong, 11 loop
//   addr       registered table index
//   busy       high while running (either direction)
//   done       one-cycle pulse when a one-shot run completes
//   wrap       one-cycle pulse on loop wrap or ping-pong turnaround
module sound_addr_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  wrap_r;

  // Configuration latched on start
  logic [ADDR_WIDTH-1:0] s_lat_r;
  logic [ADDR_WIDTH-1:0] e_lat_r;
  logic [STEP_WIDTH-1:0] st_lat_r;
  logic [1:0]            m_lat_r;

  // Candidates carry one extra bit so overshoot/underflow is visible
  logic [ADDR_WIDTH:0]   st_ext_s;
  logic [ADDR_WIDTH:0]   up_cand_s;
  logic [ADDR_WIDTH:0]   dn_cand_s;
  logic [ADDR_WIDTH:0]   s_ext_s;
  logic [ADDR_WIDTH:0]   e_ext_s;

  logic [ADDR_WIDTH-1:0] nxt_addr_s;
  state_t                nxt_state_s;
  logic                  nxt_wrap_s;
  logic                  nxt_done_s;
  logic                  advance_s;

  assign addr = addr_r;
  assign busy = busy_r;
  assign done = done_r;
  assign wrap = wrap_r;

  assign advance_s = (state_r != ST_IDLE) && tick && enable;

  // Compute the result of one advance from the current address and latched config
  always_comb begin
    st_ext_s    = {{(ADDR_WIDTH+1-STEP_WIDTH){1'b0}}, st_lat_r};
    s_ext_s     = {1'b0, s_lat_r};
    e_ext_s     = {1'b0, e_lat_r};
    up_cand_s   = {1'b0, addr_r} + st_ext_s;
    dn_cand_s   = {1'b0, addr_r} - st_ext_s;
    nxt_addr_s  = addr_r;
    nxt_state_s = state_r;
    nxt_wrap_s  = 1'b0;
    nxt_done_s  = 1'b0;
    case (m_lat_r)
      MODE_ONESHOT: begin
        if (up_cand_s > e_ext_s) begin
          // Address holds at the last in-window value
          nxt_state_s = ST_IDLE;
          nxt_done_s  = 1'b1;
        end else begin
          nxt_addr_s = up_cand_s[ADDR_WIDTH-1:0];
        end
      end
      MODE_PINGPONG: begin
        if (state_r == ST_RUN_DOWN) begin
          // MSB set means the subtraction went below zero
          if (dn_cand_s[ADDR_WIDTH] || (dn_cand_s <= s_ext_s)) begin
            nxt_addr_s  = s_lat_r;
            nxt_state_s = ST_RUN_UP;
            nxt_wrap_s  = 1'b1;
          end else begin
            nxt_addr_s = dn_cand_s[ADDR_WIDTH-1:0];
          end
        end else begin
          if (up_cand_s >= e_ext_s) begin
            nxt_addr_s  = e_lat_r;
            nxt_state_s = ST_RUN_DOWN;
            nxt_wrap_s  = 1'b1;
          end else begin
            nxt_addr_s = up_cand_s[ADDR_WIDTH-1:0];
          end
        end
      end
      default: begin
        // Loop (00 and 11)
        if (up_cand_s > e_ext_s) begin
          nxt_addr_s = s_lat_r;
          nxt_wrap_s = 1'b1;
        end else begin
          nxt_addr_s = up_cand_s[ADDR_WIDTH-1:0];
        end
      end
    endcase
  end

  // Sequencer state, latched config and registered outputs (stop > start > advance)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r  <= ST_IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      wrap_r   <= 1'b0;
      s_lat_r  <= {ADDR_WIDTH{1'b0}};
      e_lat_r  <= {ADDR_WIDTH{1'b0}};
      st_lat_r <= {STEP_WIDTH{1'b0}};
      m_lat_r  <= 2'b00;
    end else begin
      done_r <= 1'b0;
      wrap_r <= 1'b0;
      if (stop && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else if (start) begin
        s_lat_r  <= start_addr;
        e_lat_r  <= (end_addr < start_addr) ? start_addr : end_addr;
        st_lat_r <= (step == {STEP_WIDTH{1'b0}}) ?
                    {{(STEP_WIDTH-1){1'b0}}, 1'b1} : step;
        m_lat_r  <= mode;
        addr_r   <= start_addr;
        state_r  <= ST_RUN_UP;
        busy_r   <= 1'b1;
      end else if (advance_s) begin
        addr_r  <= nxt_addr_s;
        state_r <= nxt_state_s;
        busy_r  <= (nxt_state_s != ST_IDLE);
        wrap_r  <= nxt_wrap_s;
        done_r  <= nxt_done_s;
      end else begin
        state_r <= state_r;
        addr_r  <= addr_r;
      end
    end
  end

endmodule
